// File: rtl/bcd_pkg.sv
// Constants shared by the BCD converters (this block and the display-side binary-to-BCD path).
package bcd_pkg;

  localparam int        BCD_DIGIT_W = 4;
  localparam logic [3:0] ADJ_THRESH = 4'd8;
  localparam logic [3:0] ADJ_VAL    = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } bcd_state_t;

  function automatic logic digit_valid(input logic [BCD_DIGIT_W-1:0] d);
    return (d <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Reverse double-dabble digit correction: after a right shift, any digit >= 8 loses 3.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d_i,
  output logic [BCD_DIGIT_W-1:0] d_o
);

  assign d_o = (d_i >= ADJ_THRESH) ? (d_i - ADJ_VAL) : d_i;

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter: one right-shift/adjust step per clock, start/busy/done handshake.
module bcd_to_binary_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 5,
  parameter int BIN_W  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                          busy,
  output logic                          done,
  output logic [BIN_W-1:0]              bin,
  output logic                          ovf,
  output logic                          err
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  bcd_state_t       state_q, state_d;
  logic [SR_W-1:0]  sreg_q, sreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic [SR_W-1:0]  shifted;
  logic [BCD_W-1:0] adj_field;
  logic [SR_W-1:0]  sreg_step;
  logic             any_bad;

  assign shifted = sreg_q >> 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .d_i (shifted[BIN_W + BCD_DIGIT_W*g +: BCD_DIGIT_W]),
      .d_o (adj_field[BCD_DIGIT_W*g +: BCD_DIGIT_W])
    );
  end

  assign sreg_step = {adj_field, shifted[BIN_W-1:0]};

  always_comb begin
    any_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!digit_valid(bcd[BCD_DIGIT_W*i +: BCD_DIGIT_W])) any_bad = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sreg_d = {bcd, {BIN_W{1'b0}}};
          cnt_d  = '0;
          if (any_bad) begin
            // Invalid input skips shifting entirely; result is published immediately.
            state_d = ST_DONE;
            bin_d   = '0;
            ovf_d   = 1'b0;
            err_d   = 1'b1;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        sreg_d = sreg_step;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          state_d = ST_DONE;
          bin_d   = sreg_step[BIN_W-1:0];
          ovf_d   = |sreg_step[SR_W-1:BIN_W];
          err_d   = 1'b0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
  assign bin  = bin_q;
  assign ovf  = ovf_q;
  assign err  = err_q;

endmodule
